adder3_reduce_ctrl: RTL and testbench

- Sequencer that reduces a stream of signed W-bit operands to one saturated W-bit sum.
- Owns one 3-input saturating adder: accumulator + operand A + operand B, two operands consumed per beat.
- Sits between the RPU operand buffers and the neuron output stage. Replaces hand-sequenced chains of saturating adders for dot-product/partial-sum reduction.

---
 rtl/adder3_reduce_ctrl.sv | 90 +++++++++
 tb/tb_adder3_reduce_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder3_reduce_ctrl.sv
// adder3_reduce_ctrl: streams signed operand pairs through one 3-input saturating adder into a single sum.
// Optional macro ACC_INIT_EN adds init_val to preload the accumulator on start.
module adder3_reduce_ctrl #(
    parameter int W = 6,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
`ifdef ACC_INIT_EN
    input  logic [W-1:0]     init_val,
`endif
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_sum,
    output logic             out_sat
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic signed [W+1:0] SMAX = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] SMIN = {3'b111, {(W-1){1'b0}}};
    state_t state;
    logic [W-1:0] acc, b_eff, res, init;
    logic [LEN_W-1:0] rem;
    logic signed [W+1:0] sum;
    logic beat_sat, fire, two_left;
`ifdef ACC_INIT_EN
    assign init = init_val;
`else
    assign init = '0;
`endif
    assign two_left = rem >= LEN_W'(2);
    // a lone trailing operand pairs with zero instead of in_b
    assign b_eff = two_left ? in_b : '0;
    assign sum = {{2{acc[W-1]}}, acc} + {{2{in_a[W-1]}}, in_a} + {{2{b_eff[W-1]}}, b_eff};
    assign beat_sat = (sum > SMAX) || (sum < SMIN);
    assign res = sum > SMAX ? SMAX[W-1:0] : sum < SMIN ? SMIN[W-1:0] : sum[W-1:0];
    assign in_ready = state == RUN;
    assign out_valid = state == DONE;
    assign busy = state != IDLE;
    assign fire = in_valid && in_ready;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc <= '0;
            rem <= '0;
            out_sum <= '0;
            out_sat <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start && !abort) begin
                    acc <= init;
                    out_sat <= 1'b0;
                    rem <= len;
                    if (len == '0) begin
                        out_sum <= init;
                        state <= DONE;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: if (abort) begin
                    state <= IDLE;
                    acc <= '0;
                end else if (fire) begin
                    acc <= res;
                    out_sat <= out_sat | beat_sat;
                    rem <= two_left ? rem - LEN_W'(2) : '0;
                    if (rem <= LEN_W'(2)) begin
                        out_sum <= res;
                        state <= DONE;
                    end
                end
                DONE: if (abort) begin
                    state <= IDLE;
                    acc <= '0;
                end else if (out_ready) begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder3_reduce_ctrl.sv
// tb_adder3_reduce_ctrl: scoreboard bench for the saturating reduction sequencer (W=6).
module tb_adder3_reduce_ctrl;
    logic clk = 0, rst = 1, start = 0, abort = 0, in_valid = 0, out_ready = 0;
    logic [7:0] len = 0;
    logic [5:0] in_a = 0, in_b = 0;
    logic busy, in_ready, out_valid, out_sat;
    logic [5:0] out_sum;
    int passed = 0, total = 0, hs = 0;
    int m_acc, m_rem;
    bit m_st;
    int sb_sum[$];
    bit sb_sat[$];

    adder3_reduce_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_sat(out_sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (in_valid && in_ready) hs <= hs + 1;

    task automatic start_red(input int l);
        start = 1; len = 8'(l);
        @(negedge clk);
        start = 0;
        m_acc = 0; m_rem = l; m_st = 0;
    endtask

    task automatic send(input int a, input int b);
        int cnt = 0, s;
        in_a = 6'(a); in_b = 6'(b); in_valid = 1;
        while (!in_ready && cnt < 20) begin @(negedge clk); cnt++; end
        total++;
        if (cnt >= 20) $display("FAIL send_timeout in_ready=%0b want 1", in_ready);
        else passed++;
        s = m_acc + a + (m_rem >= 2 ? b : 0);
        if (s > 31) begin m_acc = 31; m_st = 1; end
        else if (s < -32) begin m_acc = -32; m_st = 1; end
        else m_acc = s;
        m_rem = m_rem >= 2 ? m_rem - 2 : 0;
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic push_exp();
        sb_sum.push_back(m_acc);
        sb_sat.push_back(m_st);
    endtask

    task automatic collect(output bit to, output int s, output bit st);
        int cnt = 0;
        while (!out_valid && cnt < 40) begin @(negedge clk); cnt++; end
        to = !out_valid;
        s = $signed(out_sum);
        st = out_sat;
        if (!to) begin
            out_ready = 1;
            @(negedge clk);
            out_ready = 0;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        total++;
        if ({busy, in_ready, out_valid, out_sat, out_sum} !== 10'd0)
            $display("FAIL reset_state got busy=%0b rdy=%0b ov=%0b sat=%0b sum=%0d want all 0",
                     busy, in_ready, out_valid, out_sat, out_sum);
        else passed++;
        start = 1; abort = 1; len = 8'd2;
        @(negedge clk);
        start = 0; abort = 0;
        total++;
        if (busy !== 1'b0) $display("FAIL start_abort_idle busy=%0b want 0", busy);
        else passed++;
    endtask

    task automatic test_basic();
        bit to, st; int s, es; bit est;
        start_red(4);
        send(3, 4); in_valid = 1; send(5, -2);
        total++;
        if (out_valid !== 1'b1) $display("FAIL basic_latency out_valid=%0b want 1", out_valid);
        else passed++;
        push_exp();
        collect(to, s, st);
        es = sb_sum.pop_front(); est = sb_sat.pop_front();
        total++;
        if (to || s !== es || st !== est) $display("FAIL basic_sum got %0d/%0b want %0d/%0b", s, st, es, est);
        else passed++;
    endtask

    task automatic test_odd_len();
        bit to, st; int s, es, h0; bit est;
        h0 = hs;
        start_red(3);
        send(10, 10); send(5, 31);
        total++;
        if (in_ready !== 1'b0) $display("FAIL odd_in_ready got %0b want 0", in_ready);
        else passed++;
        push_exp();
        collect(to, s, st);
        es = sb_sum.pop_front(); est = sb_sat.pop_front();
        total++;
        if (to || s !== es || st !== est) $display("FAIL odd_sum got %0d/%0b want %0d/%0b", s, st, es, est);
        else passed++;
        total++;
        if (hs - h0 !== 2) $display("FAIL odd_handshakes got %0d want 2", hs - h0);
        else passed++;
    endtask

    task automatic test_saturation();
        bit to, st; int s, es; bit est;
        start_red(4);
        send(31, 31); send(-5, -5);
        push_exp();
        collect(to, s, st);
        es = sb_sum.pop_front(); est = sb_sat.pop_front();
        total++;
        if (to || s !== es || st !== est) $display("FAIL sat_pullback got %0d/%0b want %0d/%0b", s, st, es, est);
        else passed++;
        start_red(2);
        send(-32, -32);
        push_exp();
        collect(to, s, st);
        es = sb_sum.pop_front(); est = sb_sat.pop_front();
        total++;
        if (to || s !== es || st !== est) $display("FAIL sat_neg got %0d/%0b want %0d/%0b", s, st, es, est);
        else passed++;
        start_red(0);
        total++;
        if (out_valid !== 1'b1) $display("FAIL len0_latency out_valid=%0b want 1", out_valid);
        else passed++;
        push_exp();
        collect(to, s, st);
        es = sb_sum.pop_front(); est = sb_sat.pop_front();
        total++;
        if (to || s !== es || st !== est) $display("FAIL len0_sum got %0d/%0b want %0d/%0b", s, st, es, est);
        else passed++;
    endtask

    task automatic test_backpressure();
        bit to, st; int s, es, h0; bit est;
        logic [5:0] s0;
        start_red(6);
        send(7, -3);
        h0 = hs;
        repeat (3) @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || hs !== h0) $display("FAIL stall_hold rdy=%0b hs=%0d want 1/%0d", in_ready, hs, h0);
        else passed++;
        send(9, 8); send(-2, 6);
        push_exp();
        s0 = out_sum;
        for (int i = 0; i < 4; i++) begin
            start = 1; len = 8'd2;
            total++;
            if (out_valid !== 1'b1 || out_sum !== s0)
                $display("FAIL done_stable ov=%0b sum=%0d want 1/%0d", out_valid, out_sum, s0);
            else passed++;
            @(negedge clk);
        end
        start = 0;
        collect(to, s, st);
        es = sb_sum.pop_front(); est = sb_sat.pop_front();
        total++;
        if (to || s !== es || st !== est) $display("FAIL bp_sum got %0d/%0b want %0d/%0b", s, st, es, est);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL bp_idle busy=%0b want 0", busy);
        else passed++;
        repeat (3) @(negedge clk);
        total++;
        if (out_valid !== 1'b0) $display("FAIL bp_single_result out_valid=%0b want 0", out_valid);
        else passed++;
    endtask

    task automatic test_abort();
        bit to, st; int s, es; bit est;
        logic [5:0] prev;
        prev = out_sum;
        start_red(6);
        send(1, 1);
        abort = 1;
        @(negedge clk);
        abort = 0;
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_sum !== prev)
            $display("FAIL abort_idle busy=%0b ov=%0b sum=%0d want 0/0/%0d", busy, out_valid, out_sum, prev);
        else passed++;
        repeat (3) @(negedge clk);
        total++;
        if (out_valid !== 1'b0) $display("FAIL abort_no_result out_valid=%0b want 0", out_valid);
        else passed++;
        start_red(2);
        send(1, 2);
        push_exp();
        collect(to, s, st);
        es = sb_sum.pop_front(); est = sb_sat.pop_front();
        total++;
        if (to || s !== es || st !== est) $display("FAIL after_abort got %0d/%0b want %0d/%0b", s, st, es, est);
        else passed++;
    endtask

    task automatic test_async_reset();
        start_red(4);
        send(31, 31);
        total++;
        if (out_sat !== m_st || busy !== 1'b1) $display("FAIL pre_rst sat=%0b busy=%0b want %0b/1", out_sat, busy, m_st);
        else passed++;
        #2 rst = 1;
        #1;
        total++;
        if ({busy, in_ready, out_valid, out_sat, out_sum} !== 10'd0)
            $display("FAIL async_rst got busy=%0b rdy=%0b ov=%0b sat=%0b sum=%0d want all 0",
                     busy, in_ready, out_valid, out_sat, out_sum);
        else passed++;
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_odd_len();
        test_saturation();
        test_backpressure();
        test_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
